// File: rtl/rv_decode_pkg.sv
// rv_decode_pkg: shared instruction-format enum, base opcodes and decoded bundle type
package rv_decode_pkg;
    localparam int PC_MAX   = 64;
    localparam int XLEN_MAX = 64;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_SB  = 3'd3,
        FMT_UJ  = 3'd4,
        FMT_U   = 3'd5,
        FMT_ILL = 3'd7
    } inst_t;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    // pc and imm are carried at their widest; the stage trims them to PC_W / XLEN
    typedef struct packed {
        logic [PC_MAX-1:0]   pc;
        inst_t               fmt;
        logic [6:0]          opcode;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [XLEN_MAX-1:0] imm;
        logic                illegal;
    } decoded_t;
endpackage

// File: rtl/inst_decode_core.sv
// inst_decode_core: combinational RV32/RV64 instruction to decoded bundle
module inst_decode_core
    import rv_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [PC_MAX-1:0] pc,
    input  logic [31:0]       inst,
    output decoded_t          dec
);
    inst_t fmt;
    logic  s;

    assign s = inst[31];

    // classify format from the opcode; the W-suffixed opcodes only exist on RV64
    always_comb begin
        fmt = FMT_ILL;
        if (inst[1:0] == 2'b11) begin
            case (inst[6:0])
                OPC_OP:                                               fmt = FMT_R;
                OPC_OP_32:                                            fmt = (XLEN == 64) ? FMT_R : FMT_ILL;
                OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: fmt = FMT_I;
                OPC_OP_IMM_32:                                        fmt = (XLEN == 64) ? FMT_I : FMT_ILL;
                OPC_STORE:                                            fmt = FMT_S;
                OPC_BRANCH:                                           fmt = FMT_SB;
                OPC_JAL:                                              fmt = FMT_UJ;
                OPC_LUI, OPC_AUIPC:                                   fmt = FMT_U;
                default:                                              fmt = FMT_ILL;
            endcase
        end
    end

    // extract the fields each format owns and build the sign-extended immediate
    always_comb begin
        dec         = '0;
        dec.pc      = pc;
        dec.fmt     = fmt;
        dec.opcode  = inst[6:0];
        dec.illegal = (fmt == FMT_ILL);
        dec.funct3  = (fmt inside {FMT_R, FMT_I, FMT_S, FMT_SB}) ? inst[14:12] : 3'd0;
        dec.funct7  = (fmt == FMT_R) ? inst[31:25] : 7'd0;
        dec.rs1     = (fmt inside {FMT_R, FMT_I, FMT_S, FMT_SB}) ? inst[19:15] : 5'd0;
        dec.rs2     = (fmt inside {FMT_R, FMT_S, FMT_SB}) ? inst[24:20] : 5'd0;
        dec.rd      = (fmt inside {FMT_R, FMT_I, FMT_U, FMT_UJ}) ? inst[11:7] : 5'd0;
        case (fmt)
            FMT_I:   dec.imm = {{52{s}}, inst[31:20]};
            FMT_S:   dec.imm = {{52{s}}, inst[31:25], inst[11:7]};
            FMT_SB:  dec.imm = {{51{s}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   dec.imm = {{32{s}}, inst[31:12], 12'h000};
            FMT_UJ:  dec.imm = {{43{s}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: dec.imm = '0;
        endcase
    end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode stage with valid/ready handshake, optional skid buffer and flush
module decode_stage
    import rv_decode_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int PC_W    = 32,
    parameter bit SKID_EN = 1'b1
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PC_W-1:0] in_pc,
    input  logic [31:0]     in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [2:0]      out_fmt,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
);
    logic [PC_MAX-1:0] pc_ext;
    decoded_t          dec, out_d, out_q, skid_d, skid_q;
    logic              out_valid_d, out_valid_q, skid_valid_d, skid_valid_q;
    logic              in_fire, out_fire, unused_bits;

    // widen the incoming pc into the shared bundle
    always_comb begin
        pc_ext            = '0;
        pc_ext[PC_W-1:0] = in_pc;
    end

    inst_decode_core #(.XLEN(XLEN)) u_core (
        .pc   (pc_ext),
        .inst (in_inst),
        .dec  (dec)
    );

    assign in_ready = SKID_EN ? !skid_valid_q : (!out_valid_q || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    // output refills from the skid first, else from the input; a stalled arrival parks in the skid
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_fire) begin
            if (skid_valid_q) out_d = skid_q;
            else if (in_fire) out_d = dec;
            out_valid_d  = skid_valid_q || in_fire;
            skid_valid_d = 1'b0;
        end else if (in_fire && SKID_EN) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    // state registers; reset empties both slots and clears the held bundle
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign unused_bits = ^{out_q.pc, out_q.imm};
    assign out_valid   = out_valid_q;
    assign out_pc      = out_q.pc[PC_W-1:0];
    assign out_fmt     = out_q.fmt;
    assign out_opcode  = out_q.opcode;
    assign out_funct3  = out_q.funct3;
    assign out_funct7  = out_q.funct7;
    assign out_rs1     = out_q.rs1;
    assign out_rs2     = out_q.rs2;
    assign out_rd      = out_q.rd;
    assign out_imm     = out_q.imm[XLEN-1:0];
    assign out_illegal = out_q.illegal;
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV32/RV64 instruction-decode pipeline stage between fetch and register-read/execute.
- Accepts {pc, inst} on a valid/ready handshake and classifies the format (R/I/S/SB/UJ/U).
- Extracts register indices and funct fields, generates the sign-extended immediate, and flags illegal encodings.
- Optional skid buffer gives full throughput under backpressure; flush input squashes in-flight entries.

Parameters:
- XLEN, 32: datapath width (32 or 64); immediate sign-extended to XLEN; 64 enables OP-IMM-32/OP-32 opcodes.
- PC_W, 32: width of the pc passthrough.
- SKID_EN, 1: 1 = two-entry (output reg + skid reg) with registered in_ready; 0 = single output reg, in_ready combinational.

Ports:
- clk  in  1  clock, rising edge
- nrst  in  1  asynchronous active-low reset
- flush  in  1  squash all held entries this cycle
- in_valid  in  1  upstream has instruction
- in_ready  out  1  stage can accept
- in_pc  in  PC_W  pc of instruction
- in_inst  in  32  raw instruction
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  downstream accepts
- out_pc  out  PC_W  pc passthrough
- out_fmt  out  3  inst_t: R=0, I=1, S=2, SB=3, UJ=4, U=5, ILL=7
- out_opcode  out  7  inst[6:0]
- out_funct3  out  3  inst[14:12], 0 for U/UJ/ILL
- out_funct7  out  7  inst[31:25] for R only, else 0
- out_rs1  out  5  inst[19:15] for R/I/S/SB, else 0
- out_rs2  out  5  inst[24:20] for R/S/SB, else 0
- out_rd  out  5  inst[11:7] for R/I/U/UJ, else 0
- out_imm  out  XLEN  sign-extended immediate, 0 for R/ILL
- out_illegal  out  1  encoding not recognised

Behaviour:
- Reset (nrst low, async): out_valid=0, skid empty, all out_* data = 0, in_ready = 1 once nrst high.
- Decode is combinational on in_inst and registered on accept. Latency: accept at edge N, out_valid high after edge N.
- Format by opcode:
  - R: 0110011; 0111011 only when XLEN=64.
  - I: 0000011, 0010011, 1100111, 0001111, 1110011; 0011011 only when XLEN=64.
  - S: 0100011. SB: 1100011. UJ: 1101111. U: 0110111, 0010111.
- Illegal: inst[1:0] != 2'b11 or unlisted opcode -> fmt=ILL, illegal=1, all fields/imm zero, pc kept. The entry still flows; no stall.
- Immediates (bit 31 sign-extends to XLEN):
  - I: inst[31:20]. S: {inst[31:25], inst[11:7]}.
  - SB: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}. UJ: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
- Transfer: in on in_valid&&in_ready; out on out_valid&&out_ready. out_* stable while out_valid&&!out_ready.
- SKID_EN=1:
  - in_ready = !skid_full (registered).
  - Input arriving while output held -> skid. On output drain, skid moves to output the same edge.
  - One transfer per cycle sustained; order preserved.
- SKID_EN=0: in_ready = !out_valid || out_ready.
- Simultaneous in and out transfer: output reg replaced with the new entry, out_valid stays 1.
- flush: next edge out_valid=0 and skid cleared. Input accepted in the flush cycle is discarded. in_ready=1 the cycle after.
- Mid-operation reset drops all entries immediately (async).

Decomposition:
- rv_decode_pkg:
  - inst_t enum.
  - opcode localparams.
  - decoded_t struct {pc, fmt, opcode, funct3, funct7, rs1, rs2, rd, imm, illegal}.
- Sub-module inst_decode_core: purely combinational inst -> decoded_t, parametrised by XLEN.
- decode_stage holds only the handshake, output register and skid register of decoded_t.

Test Plan:
- addi x1,x0,5: 0x00500093 -> fmt=I, rd=1, rs1=0, funct3=0, imm=0x00000005, illegal=0, one cycle after accept.
- sw x2,-4(x1): 0xFE20AE23 -> fmt=S, rs1=1, rs2=2, rd=0, funct3=2, imm=0xFFFFFFFC. With XLEN=64, imm=0xFFFFFFFFFFFFFFFC.
- lui x5,0x12345: 0x123452B7 -> fmt=U, rd=5, imm=0x12345000. jal x1,+2048: 0x001000EF -> fmt=UJ, rd=1, imm=0x00000800.
- Backpressure, SKID_EN=1: out_ready=0, push A, B, C back-to-back:
  - A held at output, B in skid, in_ready=0, C held upstream.
  - Then out_ready=1 -> A, B, C emerge on consecutive cycles, no drop or duplicate.
- Illegal: 0x00000000 and 0x0000005B -> fmt=7, illegal=1, imm=0, pc passed. addiw 0x0010009B is illegal at XLEN=32, fmt=I at XLEN=64.
- flush with output and skid full, plus in_valid in the same cycle -> next cycle out_valid=0, no entry emerges; nrst pulse mid-stream -> out_valid=0 asynchronously.
